// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports with busy flags, one write port, reserve request, pending count.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] Aaddr;
  logic [ADDR_W-1:0] Baddr;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              a_busy;
  logic              b_busy;
  logic [ADDR_W-1:0] Caddr;
  logic [DATA_W-1:0] C;
  logic              load;
  logic              rsv;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output Aaddr, Baddr, Caddr, C, load, rsv, rsv_addr,
    input  A, B, a_busy, b_busy, pend_cnt
  );

  modport slave (
    input  Aaddr, Baddr, Caddr, C, load, rsv, rsv_addr,
    output A, B, a_busy, b_busy, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// 2R/1W register file with pending-write scoreboard.
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  regfile_sb_if.slave  bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_en, rsv_en, cnt_inc, cnt_dec;

  assign wr_en  = bus.load && !((ZERO_REG != 0) && (bus.Caddr == '0));
  assign rsv_en = bus.rsv  && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  always_comb begin
    pend_d = pend_q;
    if (bus.load) pend_d[bus.Caddr] = 1'b0;
    if (rsv_en)   pend_d[bus.rsv_addr] = 1'b1;
  end

  // Release only counts if the same edge does not re-reserve the register.
  always_comb begin
    cnt_inc = rsv_en && !pend_q[bus.rsv_addr];
    cnt_dec = bus.load && pend_q[bus.Caddr] && !(rsv_en && (bus.rsv_addr == bus.Caddr));
    cnt_d   = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) regs_q[bus.Caddr] <= bus.C;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    bus.A      = regs_q[bus.Aaddr];
    bus.a_busy = pend_q[bus.Aaddr];
    if ((ZERO_REG != 0) && (bus.Aaddr == '0)) bus.A = '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (bus.Caddr == bus.Aaddr)) begin
      bus.A      = bus.C;
      bus.a_busy = 1'b0;
    end
`endif
  end

  always_comb begin
    bus.B      = regs_q[bus.Baddr];
    bus.b_busy = pend_q[bus.Baddr];
    if ((ZERO_REG != 0) && (bus.Baddr == '0)) bus.B = '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (bus.Caddr == bus.Baddr)) begin
      bus.B      = bus.C;
      bus.b_busy = 1'b0;
    end
`endif
  end

  assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; second instance covers ZERO_REG=0.
module tb_regfile_sb;
  logic clk;
  logic clr_n;
  int   total;
  int   bad;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) bus  ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) bus0 ();

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut  (.clk(clk), .clr_n(clr_n), .bus(bus));
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (.clk(clk), .clr_n(clr_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.load = 1'b0;  bus.rsv = 1'b0;
    bus0.load = 1'b0; bus0.rsv = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    bus.load = 1'b1; bus.Caddr = 4'd3; bus.C = 16'hFFFF;
    bus.rsv = 1'b1;  bus.rsv_addr = 4'd3;
    bus.Aaddr = 4'd3; bus.Baddr = 4'd3;
    tick(); tick();
    total++; if (bus.A !== 16'h0) begin bad++; $display("FAIL reset_A got=%h want=0000", bus.A); end
    total++; if (bus.B !== 16'h0) begin bad++; $display("FAIL reset_B got=%h want=0000", bus.B); end
    total++; if (bus.a_busy !== 1'b0 || bus.b_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b want=00", bus.a_busy, bus.b_busy); end
    total++; if (bus.pend_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.pend_cnt); end
    clr_n = 1'b1;
    bus.rsv = 1'b0; bus.C = 16'h1234;
    tick();
    idle();
    #1;
    total++; if (bus.A !== 16'h1234) begin bad++; $display("FAIL first_write_A got=%h want=1234", bus.A); end
    total++; if (bus.B !== 16'h1234) begin bad++; $display("FAIL first_write_B got=%h want=1234", bus.B); end
  endtask

  task automatic test_zero_reg();
    bus.load = 1'b1;  bus.Caddr = 4'd0;  bus.C = 16'hBEEF;
    bus0.load = 1'b1; bus0.Caddr = 4'd0; bus0.C = 16'hBEEF;
    tick();
    idle();
    bus.rsv = 1'b1;  bus.rsv_addr = 4'd0;
    bus0.rsv = 1'b1; bus0.rsv_addr = 4'd0;
    tick();
    idle();
    bus.Aaddr = 4'd0; bus0.Aaddr = 4'd0;
    #1;
    total++; if (bus.A !== 16'h0) begin bad++; $display("FAIL zero_A got=%h want=0000", bus.A); end
    total++; if (bus.a_busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", bus.a_busy); end
    total++; if (bus.pend_cnt !== 5'd0) begin bad++; $display("FAIL zero_cnt got=%0d want=0", bus.pend_cnt); end
    total++; if (bus0.A !== 16'hBEEF) begin bad++; $display("FAIL nozero_A got=%h want=beef", bus0.A); end
    total++; if (bus0.a_busy !== 1'b1) begin bad++; $display("FAIL nozero_busy got=%b want=1", bus0.a_busy); end
    total++; if (bus0.pend_cnt !== 5'd1) begin bad++; $display("FAIL nozero_cnt got=%0d want=1", bus0.pend_cnt); end
  endtask

  task automatic test_scoreboard();
    bus.rsv = 1'b1; bus.rsv_addr = 4'd5;
    tick();
    total++; if (bus.pend_cnt !== 5'd1) begin bad++; $display("FAIL sb_cnt1 got=%0d want=1", bus.pend_cnt); end
    bus.rsv_addr = 4'd6;
    tick();
    total++; if (bus.pend_cnt !== 5'd2) begin bad++; $display("FAIL sb_cnt2 got=%0d want=2", bus.pend_cnt); end
    bus.rsv_addr = 4'd5;
    tick();
    total++; if (bus.pend_cnt !== 5'd2) begin bad++; $display("FAIL sb_cnt_rersv got=%0d want=2", bus.pend_cnt); end
    idle();
    bus.Aaddr = 4'd5; bus.Baddr = 4'd6;
    #1;
    total++; if (bus.a_busy !== 1'b1) begin bad++; $display("FAIL sb_busy5 got=%b want=1", bus.a_busy); end
    total++; if (bus.b_busy !== 1'b1) begin bad++; $display("FAIL sb_busy6 got=%b want=1", bus.b_busy); end
    bus.load = 1'b1; bus.Caddr = 4'd5; bus.C = 16'h5555;
    tick();
    idle();
    #1;
    total++; if (bus.pend_cnt !== 5'd1) begin bad++; $display("FAIL sb_release_cnt got=%0d want=1", bus.pend_cnt); end
    total++; if (bus.a_busy !== 1'b0) begin bad++; $display("FAIL sb_release_busy got=%b want=0", bus.a_busy); end
    total++; if (bus.A !== 16'h5555) begin bad++; $display("FAIL sb_release_A got=%h want=5555", bus.A); end
  endtask

  task automatic test_simul_set_clear();
    bus.rsv = 1'b1; bus.rsv_addr = 4'd7;
    tick();
    bus.load = 1'b1; bus.Caddr = 4'd7; bus.C = 16'h7777;
    tick();
    idle();
    bus.Aaddr = 4'd7;
    #1;
    total++; if (bus.a_busy !== 1'b1) begin bad++; $display("FAIL simul_busy got=%b want=1", bus.a_busy); end
    total++; if (bus.pend_cnt !== 5'd2) begin bad++; $display("FAIL simul_cnt got=%0d want=2", bus.pend_cnt); end
    total++; if (bus.A !== 16'h7777) begin bad++; $display("FAIL simul_A got=%h want=7777", bus.A); end
  endtask

  task automatic test_bypass();
    bus.rsv = 1'b1; bus.rsv_addr = 4'd4;
    tick();
    idle();
    bus.Aaddr = 4'd4; bus.Baddr = 4'd4;
    bus.load = 1'b1; bus.Caddr = 4'd4; bus.C = 16'h00A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (bus.A !== 16'h00A5) begin bad++; $display("FAIL byp_A got=%h want=00a5", bus.A); end
    total++; if (bus.a_busy !== 1'b0) begin bad++; $display("FAIL byp_abusy got=%b want=0", bus.a_busy); end
    total++; if (bus.B !== 16'h00A5 || bus.b_busy !== 1'b0) begin bad++; $display("FAIL byp_B got=%h/%b want=00a5/0", bus.B, bus.b_busy); end
`else
    total++; if (bus.A !== 16'h0000) begin bad++; $display("FAIL nobyp_A got=%h want=0000", bus.A); end
    total++; if (bus.a_busy !== 1'b1) begin bad++; $display("FAIL nobyp_abusy got=%b want=1", bus.a_busy); end
    total++; if (bus.B !== 16'h0000 || bus.b_busy !== 1'b1) begin bad++; $display("FAIL nobyp_B got=%h/%b want=0000/1", bus.B, bus.b_busy); end
`endif
    tick();
    idle();
    #1;
    total++; if (bus.A !== 16'h00A5) begin bad++; $display("FAIL byp_next_A got=%h want=00a5", bus.A); end
    total++; if (bus.a_busy !== 1'b0) begin bad++; $display("FAIL byp_next_busy got=%b want=0", bus.a_busy); end
    total++; if (bus.pend_cnt !== 5'd2) begin bad++; $display("FAIL byp_next_cnt got=%0d want=2", bus.pend_cnt); end
  endtask

  task automatic test_mid_reset();
    bus.rsv = 1'b1; bus.rsv_addr = 4'd9;
    tick();
    idle();
    bus.Aaddr = 4'd6; bus.Baddr = 4'd7;
    #1;
    total++; if (bus.pend_cnt !== 5'd3) begin bad++; $display("FAIL mid_pre_cnt got=%0d want=3", bus.pend_cnt); end
    total++; if (bus.B !== 16'h7777 || bus.b_busy !== 1'b1) begin bad++; $display("FAIL mid_pre_B got=%h/%b want=7777/1", bus.B, bus.b_busy); end
    clr_n = 1'b0;
    #1;
    total++; if (bus.pend_cnt !== 5'd0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", bus.pend_cnt); end
    total++; if (bus.a_busy !== 1'b0 || bus.b_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b%b want=00", bus.a_busy, bus.b_busy); end
    total++; if (bus.B !== 16'h0000) begin bad++; $display("FAIL mid_B got=%h want=0000", bus.B); end
    clr_n = 1'b1;
    tick();
    total++; if (bus.pend_cnt !== 5'd0 || bus.B !== 16'h0000) begin bad++; $display("FAIL mid_after got=%0d/%h want=0/0000", bus.pend_cnt, bus.B); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr_n = 1'b0;
    bus.Aaddr = '0; bus.Baddr = '0; bus.Caddr = '0; bus.C = '0; bus.rsv_addr = '0;
    bus0.Aaddr = '0; bus0.Baddr = '0; bus0.Caddr = '0; bus0.C = '0; bus0.rsv_addr = '0;
    idle();
    test_reset();
    test_zero_reg();
    test_scoreboard();
    test_simul_set_clear();
    test_bypass();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read/one-write general-purpose register file for the pipelined datapath, with register 0 hard-wired to zero and an asynchronous active-low clear. It adds a pending-write scoreboard: decode reserves a destination at issue, writeback releases it, and the per-port busy flags drive the hazard/stall logic. An optional write-to-read bypass lets a same-cycle writeback satisfy a read.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never pending; 0 = register 0 is ordinary

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset; clears all registers and the scoreboard
- Aaddr  in  ADDR_W  read address, port A
- Baddr  in  ADDR_W  read address, port B
- A  out  DATA_W  read data, port A (combinational)
- B  out  DATA_W  read data, port B (combinational)
- a_busy  out  1  register at Aaddr has an outstanding reservation
- b_busy  out  1  register at Baddr has an outstanding reservation
- Caddr  in  ADDR_W  write address
- C  in  DATA_W  write data
- load  in  1  write enable; also releases the reservation on Caddr
- rsv  in  1  reserve request (instruction issued with a destination)
- rsv_addr  in  ADDR_W  register to reserve
- pend_cnt  out  ADDR_W+1  registered count of pending registers

## Operation
- Storage: 2**ADDR_W × DATA_W array `regs`, plus a pending bit vector `pend` of 2**ADDR_W bits.
- Write: on posedge clk with load=1, regs[Caddr] <= C. When ZERO_REG=1 and Caddr=0, the write is dropped.
- Read: A = regs[Aaddr]; when ZERO_REG=1 and Aaddr=0, A = 0. Port B behaves identically with Baddr.
- Scoreboard update, on each posedge:
  - load=1 clears pend[Caddr].
  - rsv=1 sets pend[rsv_addr].
  - If both target the same address, set wins: a new producer is issued while the old one retires.
  - When ZERO_REG=1, address 0 is never set.
- Busy: a_busy = pend[Aaddr], qualified by the bypass (see Configuration). b_busy is the same for Baddr.
- pend_cnt: next value = current + (set of a clear bit) − (clear of a set bit). Net change per cycle is −1, 0 or +1.
  - Reserving an already-pending register leaves the count unchanged.
  - Loading a non-pending register leaves the count unchanged (the data is still written).
  - Invariant: pend_cnt always equals popcount(pend). Maximum value is 2**ADDR_W − ZERO_REG.
- Reset (clr_n=0, asynchronous):
  - All regs = 0, all pend = 0, pend_cnt = 0.
  - Consequently A = 0, B = 0, a_busy = 0, b_busy = 0 while reset is held.
  - Asserting reset mid-operation discards in-flight reservations and writes of that cycle.
  - The first write after reset takes effect on the first posedge with clr_n=1.

## Timing
- Write latency: one edge. Data written at edge k is visible on A/B after edge k with no bypass.
- Reservation latency: busy is raised from the edge where rsv is sampled; the same-cycle read of rsv_addr is not busy.
- Release: pend clears at the load edge. With the bypass, busy drops combinationally in the cycle load is high.
- pend_cnt is registered and updates on the same edge as pend.
- There are no back-pressure or handshake stalls. rsv and load are accepted every cycle.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: when load=1, Caddr=Aaddr and the write is not dropped, then A = C and a_busy = 0. Port B uses the same rule. Net effect: writeback-to-decode forwarding with zero stall.
- Undefined: A/B always read the stored array, and a_busy/b_busy = pend[addr] even during the releasing load cycle. The consumer stalls one extra cycle.
- The scoreboard and write behaviour are identical either way.

## Test plan
All scenarios use default parameters unless noted.
- Reset: hold clr_n=0, drive load=1, C=16'hFFFF -> A=B=0, a_busy=b_busy=0, pend_cnt=0. Release reset, write reg 3 = 16'h1234, then read -> A=16'h1234 the following cycle.
- Zero register: load=1, Caddr=0, C=16'hBEEF; then rsv=1, rsv_addr=0 -> A(Aaddr=0)=0, a_busy=0, pend_cnt=0. Repeat with ZERO_REG=0 -> A=16'hBEEF, pend_cnt=1.
- Scoreboard: reserve regs 5, 6, 5 on three consecutive cycles -> pend_cnt=1, 2, 2; a_busy=1 at Aaddr=5. Then load reg 5 -> pend_cnt=1, a_busy=0.
- Simultaneous set/clear: rsv_addr=7 and Caddr=7 in the same cycle with reg 7 pending -> pend[7] stays 1, pend_cnt unchanged, regs[7]=C.
- Bypass: reg 4 pending; drive load=1, Caddr=4, C=16'h00A5 with Aaddr=4.
  - With `REGFILE_BYPASS_EN`: A=16'h00A5, a_busy=0 in that cycle.
  - Without it: old value on A and a_busy=1 in that cycle; A=16'h00A5 and a_busy=0 on the next cycle.
- Mid-operation reset: pend_cnt=3, then pulse clr_n low between edges -> pend_cnt, busy flags and all reads go to 0 immediately, without waiting for a clock edge.
